// File: rtl/mips_multicycle_cpu.sv
// Multi-cycle MIPS32-subset core: one shared ALU, 32x32 register file and a unified
// instruction/data memory port with a req/ready handshake tolerant of any wait states.
module mips_multicycle_cpu #(
    parameter int unsigned ADDR_W           = 32,
    parameter int unsigned RESET_PC         = 0,
    parameter bit          HALT_ON_MISALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc_o,
    output logic [2:0]        state_o,
    output logic              retire_o,
    output logic              halt_o
);
    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00, OpJ    = 6'h02, OpJal  = 6'h03, OpBeq = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05, OpAddi = 6'h08, OpSlti = 6'h0A, OpAndi = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D, OpLw   = 6'h23, OpSw   = 6'h2B;
    localparam logic [5:0] FnJr    = 6'h08, FnAdd  = 6'h20, FnSub  = 6'h22, FnAnd  = 6'h24;
    localparam logic [5:0] FnOr    = 6'h25, FnSlt  = 6'h2A;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d, mdr_q, mdr_d, a_q, a_d, b_q, b_d, alu_out_q, alu_out_d;
    logic              retire_q, retire_d;
    logic [31:0]       regs [32];

    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sext_imm, zext_imm, pc32, jump_target, alu_b, alu_res;
    logic        is_r, is_jr, is_branch, is_mem, legal, xfer, misaligned;
    logic        unused_shamt;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
    assign zext_imm = {16'h0000, ir_q[15:0]};
    assign pc32     = 32'(pc_q);
    // Jump keeps the top nibble of the already-incremented PC.
    assign jump_target = (pc32 & 32'hF000_0000) | {4'h0, ir_q[25:0], 2'b00};
    assign unused_shamt = ^ir_q[10:6];

    assign is_r      = (op == OpRtype);
    assign is_jr     = is_r && (funct == FnJr);
    assign is_branch = (op == OpBeq) || (op == OpBne);
    assign is_mem    = (op == OpLw) || (op == OpSw);
    assign legal     = is_r ? (funct inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt, FnJr})
                            : (op inside {OpAddi, OpAndi, OpOri, OpSlti, OpLw, OpSw,
                                          OpBeq, OpBne, OpJ, OpJal});

    // Single shared ALU; operand B depends on instruction class.
    always_comb begin
        alu_b = is_r ? b_q : (((op == OpAndi) || (op == OpOri)) ? zext_imm : sext_imm);
        if (is_r && funct == FnSub) begin
            alu_res = a_q - alu_b;
        end else if ((is_r && funct == FnAnd) || op == OpAndi) begin
            alu_res = a_q & alu_b;
        end else if ((is_r && funct == FnOr) || op == OpOri) begin
            alu_res = a_q | alu_b;
        end else if ((is_r && funct == FnSlt) || op == OpSlti) begin
            alu_res = {31'h0, $signed(a_q) < $signed(alu_b)};
        end else begin
            alu_res = a_q + alu_b;
        end
    end

    assign misaligned = (alu_res[1:0] != 2'b00);

    assign mem_req   = rst && ((state_q == StFetch) || (state_q == StMem));
    assign mem_we    = (state_q == StMem) && (op == OpSw);
    assign mem_addr  = (state_q == StMem) ? alu_out_q[ADDR_W-1:0] : pc_q;
    assign mem_wdata = b_q;
    assign xfer      = mem_req && mem_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        retire_d  = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = 5'd0;
        rf_wdata  = 32'h0;
        unique case (state_q)
            StFetch: begin
                if (xfer) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d       = regs[rs];
                b_d       = regs[rt];
                alu_out_d = pc32 + {sext_imm[29:0], 2'b00};
                if (!legal) begin
                    state_d = StHalt;
                end else if (op == OpJ || op == OpJal) begin
                    pc_d     = jump_target[ADDR_W-1:0];
                    retire_d = 1'b1;
                    state_d  = StFetch;
                    if (op == OpJal) begin
                        rf_we    = 1'b1;
                        rf_waddr = 5'd31;
                        rf_wdata = pc32;
                    end
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (is_branch) begin
                    if ((a_q == b_q) == (op == OpBeq)) pc_d = alu_out_q[ADDR_W-1:0];
                    retire_d = 1'b1;
                    state_d  = StFetch;
                end else if (is_jr) begin
                    pc_d     = a_q[ADDR_W-1:0];
                    retire_d = 1'b1;
                    state_d  = StFetch;
                end else if (is_mem) begin
                    // Aligned addresses already end in 00, so forcing is harmless there.
                    alu_out_d = {alu_res[31:2], 2'b00};
                    state_d   = (misaligned && HALT_ON_MISALIGN) ? StHalt : StMem;
                end else begin
                    alu_out_d = alu_res;
                    state_d   = StWb;
                end
            end
            StMem: begin
                if (xfer) begin
                    if (op == OpSw) begin
                        retire_d = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                rf_we    = 1'b1;
                rf_waddr = is_r ? rd : rt;
                rf_wdata = (op == OpLw) ? mdr_q : alu_out_q;
                retire_d = 1'b1;
                state_d  = StFetch;
            end
            default: state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFetch;
            pc_q      <= ADDR_W'(RESET_PC);
            ir_q      <= 32'h0;
            mdr_q     <= 32'h0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            alu_out_q <= 32'h0;
            retire_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            retire_q  <= retire_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    assign pc_o     = pc_q;
    assign state_o  = state_q;
    assign retire_o = retire_q;
    assign halt_o   = (state_q == StHalt);

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Directed bench for mips_multicycle_cpu: small programs run from a wait-state memory model,
// observed through the memory port, PC, state and retire pulses.
module tb_mips_multicycle_cpu;
    localparam logic [5:0] OpJ = 6'h02, OpJal = 6'h03, OpBeq = 6'h04, OpBne = 6'h05;
    localparam logic [5:0] OpAddi = 6'h08, OpLw = 6'h23, OpSw = 6'h2B;
    localparam logic [31:0] Illegal = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req, mem_we, mem_ready, retire_o, halt_o;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;
    logic [2:0]  state_o;

    int checks = 0;
    int fails  = 0;

    logic [31:0]   imem [1024];
    logic [31:0]   dmem [1024];
    logic [1023:0] dvalid;
    logic [9:0]    widx;
    int wait_code = 0;
    int wait_data = 0;
    int wait_cnt;

    int          cyc, ret_cnt, st_cnt;
    int          ret_cyc [16];
    logic [31:0] ret_pc  [16];
    logic [31:0] st_addr [16];
    logic [31:0] st_data [16];

    mips_multicycle_cpu #(
        .ADDR_W(32),
        .RESET_PC(32'h100),
        .HALT_ON_MISALIGN(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .pc_o(pc_o),
        .state_o(state_o),
        .retire_o(retire_o),
        .halt_o(halt_o)
    );

    always #5 clk = ~clk;

    // Low page (below 0x100) is the data region with its own wait-state count.
    assign widx      = mem_addr[11:2];
    assign mem_rdata = dvalid[widx] ? dmem[widx] : imem[widx];
    assign mem_ready = wait_cnt >= ((mem_addr < 32'h100) ? wait_data : wait_code);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 0;
            dvalid   <= '0;
            cyc      <= 0;
            ret_cnt  <= 0;
            st_cnt   <= 0;
        end else begin
            cyc <= cyc + 1;
            wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;
            if (retire_o && ret_cnt < 16) begin
                ret_cyc[ret_cnt] <= cyc;
                ret_pc[ret_cnt]  <= pc_o;
                ret_cnt          <= ret_cnt + 1;
            end
            if (mem_req && mem_ready && mem_we) begin
                dmem[widx]   <= mem_wdata;
                dvalid[widx] <= 1'b1;
                if (st_cnt < 16) begin
                    st_addr[st_cnt] <= mem_addr;
                    st_data[st_cnt] <= mem_wdata;
                    st_cnt          <= st_cnt + 1;
                end
            end
        end
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'h00, funct};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] target);
        return {op, target[27:2]};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) imem[i] = Illegal;
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        imem[addr[11:2]] = word;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_until_halt(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halt_o) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clear_prog();
        put(32'h100, enc_i(OpAddi, 5'd0, 5'd1, 16'd5));
        wait_code = 3;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, state_o, retire_o, halt_o} !== 6'b0_000_0_0) begin
            fails++;
            $display("FAIL reset_outputs: req/state/ret/halt=%b expected 000000",
                     {mem_req, state_o, retire_o, halt_o});
        end
        checks++;
        if (pc_o !== 32'h100) begin
            fails++;
            $display("FAIL reset_pc: got %h expected 00000100", pc_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, state_o} !== {1'b1, 1'b0, 32'h100, 3'd0}) begin
            fails++;
            $display("FAIL first_fetch: req=%b we=%b addr=%h state=%0d expected 1 0 100 0",
                     mem_req, mem_we, mem_addr, state_o);
        end
        @(negedge clk);
        checks++;
        if ({mem_req, state_o} !== {1'b1, 3'd0}) begin
            fails++;
            $display("FAIL fetch_stall: req=%b state=%0d expected 1 0", mem_req, state_o);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_fetch: mem_req=%b expected 0", mem_req);
        end
        wait_code = 0;
    endtask

    task automatic test_alu();
        bit to;
        clear_prog();
        put(32'h100, enc_i(OpAddi, 5'd0, 5'd1, 16'd5));
        put(32'h104, enc_i(OpAddi, 5'd0, 5'd2, 16'hFFFD));
        put(32'h108, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
        put(32'h10C, enc_r(5'd2, 5'd1, 5'd4, 6'h2A));
        put(32'h110, enc_i(OpSw, 5'd0, 5'd3, 16'h0300));
        put(32'h114, enc_i(OpSw, 5'd0, 5'd4, 16'h0304));
        apply_reset();
        run_until_halt(200, to);
        checks++;
        if (to || ret_cnt != 6) begin
            fails++;
            $display("FAIL alu_retires: timeout=%0d retires=%0d expected 0 6", to, ret_cnt);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (ret_cyc[i] - ret_cyc[i-1] != 4) begin
                fails++;
                $display("FAIL alu_spacing%0d: got %0d cycles expected 4", i,
                         ret_cyc[i] - ret_cyc[i-1]);
            end
        end
        checks++;
        if (st_data[0] !== 32'h2 || st_addr[0] !== 32'h300) begin
            fails++;
            $display("FAIL add_result: R3=%h at %h expected 00000002 at 00000300",
                     st_data[0], st_addr[0]);
        end
        checks++;
        if (st_data[1] !== 32'h1) begin
            fails++;
            $display("FAIL slt_result: R4=%h expected 00000001", st_data[1]);
        end
    endtask

    task automatic test_mem_wait();
        bit to;
        bit found;
        clear_prog();
        put(32'h100, enc_i(OpAddi, 5'd0, 5'd3, 16'd2));
        put(32'h104, enc_i(OpSw, 5'd0, 5'd3, 16'h0008));
        put(32'h108, enc_i(OpLw, 5'd0, 5'd5, 16'h0008));
        put(32'h10C, enc_i(OpSw, 5'd0, 5'd5, 16'h0308));
        wait_data = 3;
        apply_reset();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (state_o == 3'd3) found = 1'b1;
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL sw_mem_entry: state 3 not reached, state=%0d", state_o);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, state_o} !==
                {1'b1, 1'b1, 32'h8, 32'h2, 3'd3}) begin
                fails++;
                $display("FAIL sw_hold%0d: req=%b we=%b addr=%h wdata=%h state=%0d expected 1 1 8 2 3",
                         k, mem_req, mem_we, mem_addr, mem_wdata, state_o);
            end
            if (k < 3) @(negedge clk);
        end
        run_until_halt(200, to);
        checks++;
        if (to || ret_cnt != 4) begin
            fails++;
            $display("FAIL mem_retires: timeout=%0d retires=%0d expected 0 4", to, ret_cnt);
        end
        checks++;
        if (ret_cyc[1] - ret_cyc[0] != 7) begin
            fails++;
            $display("FAIL sw_cycles: got %0d expected 7", ret_cyc[1] - ret_cyc[0]);
        end
        checks++;
        if (ret_cyc[2] - ret_cyc[1] != 8) begin
            fails++;
            $display("FAIL lw_cycles: got %0d expected 8", ret_cyc[2] - ret_cyc[1]);
        end
        checks++;
        if (st_data[1] !== 32'h2 || st_addr[1] !== 32'h308) begin
            fails++;
            $display("FAIL lw_result: R5=%h at %h expected 00000002 at 00000308",
                     st_data[1], st_addr[1]);
        end
        wait_data = 0;
    endtask

    task automatic test_branch();
        bit to;
        clear_prog();
        put(32'h100, enc_i(OpAddi, 5'd0, 5'd0, 16'd7));
        put(32'h104, enc_i(OpBeq, 5'd0, 5'd0, 16'h0001));
        put(32'h108, enc_j(OpJ, 32'h114));
        put(32'h10C, enc_i(OpBeq, 5'd0, 5'd0, 16'hFFFE));
        put(32'h114, enc_i(OpBne, 5'd0, 5'd0, 16'h0005));
        put(32'h118, enc_i(OpSw, 5'd0, 5'd0, 16'h0310));
        apply_reset();
        run_until_halt(200, to);
        checks++;
        if (to || ret_cnt != 6) begin
            fails++;
            $display("FAIL br_retires: timeout=%0d retires=%0d expected 0 6", to, ret_cnt);
        end
        checks++;
        if (ret_pc[1] !== 32'h10C) begin
            fails++;
            $display("FAIL beq_fwd_pc: got %h expected 0000010c", ret_pc[1]);
        end
        checks++;
        if (ret_pc[2] !== 32'h108 || ret_cyc[2] - ret_cyc[1] != 3) begin
            fails++;
            $display("FAIL beq_back: pc=%h cycles=%0d expected 00000108 3",
                     ret_pc[2], ret_cyc[2] - ret_cyc[1]);
        end
        checks++;
        if (ret_pc[4] !== 32'h118 || ret_cyc[4] - ret_cyc[3] != 3) begin
            fails++;
            $display("FAIL bne_not_taken: pc=%h cycles=%0d expected 00000118 3",
                     ret_pc[4], ret_cyc[4] - ret_cyc[3]);
        end
        checks++;
        if (st_data[0] !== 32'h0) begin
            fails++;
            $display("FAIL r0_write: R0=%h expected 00000000", st_data[0]);
        end
    endtask

    task automatic test_jal_jr();
        bit to;
        clear_prog();
        put(32'h100, enc_j(OpJ, 32'h40));
        put(32'h040, enc_j(OpJal, 32'h200));
        put(32'h044, enc_i(OpSw, 5'd0, 5'd31, 16'h0314));
        put(32'h200, enc_r(5'd31, 5'd0, 5'd0, 6'h08));
        apply_reset();
        run_until_halt(200, to);
        checks++;
        if (to || ret_cnt != 4) begin
            fails++;
            $display("FAIL jal_retires: timeout=%0d retires=%0d expected 0 4", to, ret_cnt);
        end
        checks++;
        if (ret_pc[1] !== 32'h200 || ret_cyc[1] - ret_cyc[0] != 2) begin
            fails++;
            $display("FAIL jal_target: pc=%h cycles=%0d expected 00000200 2",
                     ret_pc[1], ret_cyc[1] - ret_cyc[0]);
        end
        checks++;
        if (ret_pc[2] !== 32'h44 || ret_cyc[2] - ret_cyc[1] != 3) begin
            fails++;
            $display("FAIL jr_return: pc=%h cycles=%0d expected 00000044 3",
                     ret_pc[2], ret_cyc[2] - ret_cyc[1]);
        end
        checks++;
        if (st_data[0] !== 32'h44) begin
            fails++;
            $display("FAIL jal_link: R31=%h expected 00000044", st_data[0]);
        end
    endtask

    task automatic test_halt(input logic [31:0] word, input string tag);
        bit to;
        bit seen_req;
        clear_prog();
        put(32'h100, word);
        apply_reset();
        run_until_halt(50, to);
        seen_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen_req |= mem_req;
        end
        checks++;
        if (to || {halt_o, state_o, seen_req} !== {1'b1, 3'd5, 1'b0}) begin
            fails++;
            $display("FAIL %s_halt: timeout=%0d halt=%b state=%0d req_seen=%b expected 0 1 5 0",
                     tag, to, halt_o, state_o, seen_req);
        end
        checks++;
        if (ret_cnt != 0 || pc_o !== 32'h104) begin
            fails++;
            $display("FAIL %s_frozen: retires=%0d pc=%h expected 0 00000104", tag, ret_cnt, pc_o);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({halt_o, state_o} !== {1'b0, 3'd0}) begin
            fails++;
            $display("FAIL %s_reset_exit: halt=%b state=%0d expected 0 0", tag, halt_o, state_o);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem_wait();
        test_branch();
        test_jal_jr();
        test_halt(Illegal, "illegal_op");
        test_halt(enc_i(OpLw, 5'd0, 5'd1, 16'h0003), "misaligned_lw");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
